// File: rtl/decode_stage_pipe.sv
// RV32-style decode stage: register file, immediate generation, load-use interlock, ID/EX register with flush.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data into captured operands instead of stalling.
module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int STALLW = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [AW-1:0]     ex_rd_o,
    output logic              ex_rd_we_o,
    output logic              ex_is_load_o,
    output logic [2:0]        ex_fmt_o,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [STALLW-1:0] stall_cnt_o
);

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;

    logic [XLEN-1:0] rf [NREGS];

    logic [6:0]      opcode;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [AW-1:0]   rs1_idx, rs2_idx;
    logic [2:0]      fmt_raw, fmt;
    logic            rs1_use, rs2_use, rd_we, is_load;
    logic [XLEN-1:0] imm, rs1_rf, rs2_rf, rs1_val, rs2_val;
    logic            load_haz, wb_haz, hazard, advance;

    assign opcode  = instr_i[6:0];
    assign rd_f    = instr_i[11:7];
    assign rs1_f   = instr_i[19:15];
    assign rs2_f   = instr_i[24:20];
    assign rs1_idx = AW'(rs1_f);
    assign rs2_idx = AW'(rs2_f);
    assign is_load = (opcode == 7'b0000011);

    always_comb begin
        fmt_raw = FMT_ILL;
        unique case (opcode)
            7'b0110011:                         fmt_raw = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: fmt_raw = FMT_I;
            7'b0100011:                         fmt_raw = FMT_S;
            7'b1100011:                         fmt_raw = FMT_B;
            7'b0110111, 7'b0010111:             fmt_raw = FMT_U;
            7'b1101111:                         fmt_raw = FMT_J;
            default:                            fmt_raw = FMT_ILL;
        endcase
    end

    // Any referenced register index beyond NREGS makes the instruction illegal.
    always_comb begin
        logic u1, u2, wr;
        u1  = (fmt_raw == FMT_R) || (fmt_raw == FMT_I) || (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
        u2  = (fmt_raw == FMT_R) || (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
        wr  = (fmt_raw == FMT_R) || (fmt_raw == FMT_I) || (fmt_raw == FMT_U) || (fmt_raw == FMT_J);
        fmt = fmt_raw;
        if ((u1 && 32'(rs1_f) >= 32'(NREGS)) || (u2 && 32'(rs2_f) >= 32'(NREGS)) ||
            (wr && 32'(rd_f) >= 32'(NREGS)))
            fmt = FMT_ILL;
        rs1_use = u1 && (fmt != FMT_ILL);
        rs2_use = u2 && (fmt != FMT_ILL);
        rd_we   = wr && (fmt != FMT_ILL) && (rd_f != 5'd0);
    end

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I:   imm = XLEN'($signed(instr_i[31:20]));
            FMT_S:   imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            FMT_B:   imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({instr_i[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

    assign rs1_rf = (rs1_f != 5'd0 && 32'(rs1_f) < 32'(NREGS)) ? rf[rs1_idx] : '0;
    assign rs2_rf = (rs2_f != 5'd0 && 32'(rs2_f) < 32'(NREGS)) ? rf[rs2_idx] : '0;

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val = (wb_we_i && wb_rd_i != '0 && wb_rd_i == rs1_idx) ? wb_data_i : rs1_rf;
    assign rs2_val = (wb_we_i && wb_rd_i != '0 && wb_rd_i == rs2_idx) ? wb_data_i : rs2_rf;
    assign wb_haz  = 1'b0;
`else
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
    // Without forwarding, wait one cycle so the register file holds the new value.
    assign wb_haz  = wb_we_i && (wb_rd_i != '0) &&
                     ((rs1_use && wb_rd_i == rs1_idx) || (rs2_use && wb_rd_i == rs2_idx));
`endif

    assign load_haz   = ex_valid_o && ex_is_load_o && (ex_rd_o != '0) &&
                        ((rs1_use && rs1_idx == ex_rd_o) || (rs2_use && rs2_idx == ex_rd_o));
    assign hazard     = if_valid_i && (load_haz || wb_haz);
    assign advance    = !ex_valid_o || ex_ready_i;
    assign if_ready_o = (advance && !hazard) || flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_we_i && wb_rd_i != '0 && 32'(wb_rd_i) < 32'(NREGS)) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_pc_o       <= '0;
            ex_rd_o       <= '0;
            ex_rd_we_o    <= 1'b0;
            ex_is_load_o  <= 1'b0;
            ex_fmt_o      <= '0;
            stall_cnt_o   <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (advance && hazard) begin
            ex_valid_o <= 1'b0;
            if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STALLW'(1);
        end else if (advance && if_valid_i) begin
            ex_valid_o    <= 1'b1;
            ex_rs1_data_o <= rs1_val;
            ex_rs2_data_o <= rs2_val;
            ex_imm_o      <= imm;
            ex_pc_o       <= pc_i;
            ex_rd_o       <= AW'(rd_f);
            ex_rd_we_o    <= rd_we;
            ex_is_load_o  <= is_load;
            ex_fmt_o      <= fmt;
        end else if (advance) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed-vector bench for decode_stage_pipe; expectations adapt to DECODE_WB_BYPASS_EN.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, flush, ex_ready, ex_valid;
    logic [31:0] instr, pc, ex_rs1, ex_rs2, ex_imm, ex_pc, wb_data;
    logic [4:0]  ex_rd, wb_rd;
    logic        ex_rd_we, ex_is_load, wb_we;
    logic [2:0]  ex_fmt;
    logic [15:0] stall_cnt, exp_stall;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(ex_valid), .ex_rs1_data_o(ex_rs1), .ex_rs2_data_o(ex_rs2),
        .ex_imm_o(ex_imm), .ex_pc_o(ex_pc), .ex_rd_o(ex_rd), .ex_rd_we_o(ex_rd_we),
        .ex_is_load_o(ex_is_load), .ex_fmt_o(ex_fmt), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .stall_cnt_o(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 0; instr = 0; pc = 0; flush = 0; ex_ready = 1;
        wb_we = 0; wb_rd = 0; wb_data = 0; exp_stall = 0;
        #3;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        checks++; if (ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_rd_we !== 1'b0) begin
            errors++; $display("FAIL reset_payload got pc=%h imm=%h we=%b want zeros", ex_pc, ex_imm, ex_rd_we); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        if_valid = 1; instr = 32'h0050_0093; pc = 32'h100; ex_ready = 1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL addi_if_ready got %b want 1", if_ready); end
        tick();
        if_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_fmt !== 3'd1 || ex_imm !== 32'd5) begin
            errors++; $display("FAIL addi_decode got v=%b fmt=%0d imm=%h want 1 1 00000005", ex_valid, ex_fmt, ex_imm); end
        checks++; if (ex_rd !== 5'd1 || ex_rd_we !== 1'b1 || ex_pc !== 32'h100 || ex_rs1 !== 32'd0) begin
            errors++; $display("FAIL addi_fields got rd=%0d we=%b pc=%h rs1=%h want 1 1 100 0", ex_rd, ex_rd_we, ex_pc, ex_rs1); end
    endtask

    task automatic test_wb_same_cycle();
        if_valid = 1; instr = 32'h0021_01B3; pc = 32'h104;
        wb_we = 1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL wb_if_ready got %b want 1", if_ready); end
        tick();
        wb_we = 0; if_valid = 0;
`else
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL wb_if_ready got %b want 0", if_ready); end
        tick();
        wb_we = 0;
        exp_stall = exp_stall + 16'd1;
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL wb_bubble got v=%b stall=%0d want 0 %0d", ex_valid, stall_cnt, exp_stall); end
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL wb_retry_ready got %b want 1", if_ready); end
        tick();
        if_valid = 0;
`endif
        checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 32'hDEAD_BEEF || ex_rs2 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_operands got v=%b rs1=%h rs2=%h want 1 deadbeef deadbeef", ex_valid, ex_rs1, ex_rs2); end
        checks++; if (ex_fmt !== 3'd0 || ex_rd !== 5'd3 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL wb_add got fmt=%0d rd=%0d stall=%0d want 0 3 %0d", ex_fmt, ex_rd, stall_cnt, exp_stall); end
    endtask

    task automatic test_load_use();
        if_valid = 1; instr = 32'h0003_2283; pc = 32'h200;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_rd !== 5'd5) begin
            errors++; $display("FAIL lw_issue got v=%b ld=%b rd=%0d want 1 1 5", ex_valid, ex_is_load, ex_rd); end
        instr = 32'h0002_83B3; pc = 32'h204;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_if_ready got %b want 0", if_ready); end
        tick();
        exp_stall = exp_stall + 16'd1;
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== exp_stall || ex_rd !== 5'd5) begin
            errors++; $display("FAIL lu_bubble got v=%b stall=%0d rd=%0d want 0 %0d 5", ex_valid, stall_cnt, ex_rd, exp_stall); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", if_ready); end
        tick();
        if_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_is_load !== 1'b0 || ex_pc !== 32'h204) begin
            errors++; $display("FAIL lu_add got v=%b rd=%0d ld=%b pc=%h want 1 7 0 204", ex_valid, ex_rd, ex_is_load, ex_pc); end
    endtask

    task automatic test_backpressure();
        if_valid = 1; instr = 32'hFFF0_0413; pc = 32'h300;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFFF || ex_rd !== 5'd8) begin
            errors++; $display("FAIL bp_issue got v=%b imm=%h rd=%0d want 1 ffffffff 8", ex_valid, ex_imm, ex_rd); end
        ex_ready = 0; instr = 32'h0050_0093; pc = 32'h304;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready cyc%0d got %b want 0", c, if_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFFF || ex_pc !== 32'h300 || stall_cnt !== exp_stall) begin
                errors++; $display("FAIL bp_hold cyc%0d got v=%b imm=%h pc=%h stall=%0d", c, ex_valid, ex_imm, ex_pc, stall_cnt); end
        end
        ex_ready = 1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", if_ready); end
        tick();
        if_valid = 0;
        checks++; if (ex_rd !== 5'd1 || ex_imm !== 32'd5 || ex_pc !== 32'h304) begin
            errors++; $display("FAIL bp_next got rd=%0d imm=%h pc=%h want 1 5 304", ex_rd, ex_imm, ex_pc); end
    endtask

    task automatic test_flush_hazard();
        if_valid = 1; instr = 32'h0003_2283; pc = 32'h400;
        tick();
        instr = 32'h0002_83B3; pc = 32'h404; flush = 1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_if_ready got %b want 1", if_ready); end
        tick();
        flush = 0; if_valid = 0;
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== exp_stall) begin
            errors++; $display("FAIL flush_result got v=%b stall=%0d want 0 %0d", ex_valid, stall_cnt, exp_stall); end
    endtask

    task automatic test_back_to_back_imm();
        if_valid = 1; instr = 32'hFE00_0EE3; pc = 32'h500;
        tick();
        checks++; if (ex_fmt !== 3'd3 || ex_imm !== 32'hFFFF_FFFC || ex_rd_we !== 1'b0) begin
            errors++; $display("FAIL beq got fmt=%0d imm=%h we=%b want 3 fffffffc 0", ex_fmt, ex_imm, ex_rd_we); end
        instr = 32'h7FFF_F0EF; pc = 32'h504;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_fmt !== 3'd5 || ex_imm !== 32'h000F_FFFE || ex_rd !== 5'd1 || ex_rd_we !== 1'b1) begin
            errors++; $display("FAIL jal got v=%b fmt=%0d imm=%h rd=%0d we=%b want 1 5 000ffffe 1 1", ex_valid, ex_fmt, ex_imm, ex_rd, ex_rd_we); end
        instr = 32'h0000_FFFF; pc = 32'h508;
        tick();
        if_valid = 0;
        checks++; if (ex_fmt !== 3'd7 || ex_rd_we !== 1'b0 || ex_imm !== 32'd0) begin
            errors++; $display("FAIL illegal got fmt=%0d we=%b imm=%h want 7 0 0", ex_fmt, ex_rd_we, ex_imm); end
    endtask

    task automatic test_x0();
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
        tick();
        wb_we = 0;
        if_valid = 1; instr = 32'h0020_04B3; pc = 32'h600;
        tick();
        if_valid = 0;
        checks++; if (ex_rs1 !== 32'd0 || ex_rs2 !== 32'hDEAD_BEEF || ex_rd !== 5'd9) begin
            errors++; $display("FAIL x0_read got rs1=%h rs2=%h rd=%0d want 0 deadbeef 9", ex_rs1, ex_rs2, ex_rd); end
    endtask

    task automatic test_reset_mid_stall();
        if_valid = 1; instr = 32'h0003_2283; pc = 32'h700;
        tick();
        instr = 32'h0002_83B3;
        tick();
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== exp_stall + 16'd1) begin
            errors++; $display("FAIL mid_stall got v=%b stall=%0d want 0 %0d", ex_valid, stall_cnt, exp_stall + 16'd1); end
        rst_n = 0;
        #1;
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b stall=%0d rd=%0d ld=%b want zeros", ex_valid, stall_cnt, ex_rd, ex_is_load); end
        tick();
        rst_n = 1; instr = 32'h0020_04B3;
        tick();
        if_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_rs2 !== 32'd0) begin
            errors++; $display("FAIL rf_cleared got v=%b rs2=%h want 1 0", ex_valid, ex_rs2); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wb_same_cycle();
        test_load_use();
        test_backpressure();
        test_flush_hazard();
        test_back_to_back_imm();
        test_x0();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised next-generation decode stage for the RV32-style core.
- Sits between fetch and execute. Contains:
  - the architectural register file,
  - immediate generation for all formats,
  - a load-use hazard interlock,
  - a valid/ready-handshaked ID/EX pipeline register with flush.
- Generalises register width/count and adds the stall, flush and bypass behaviour the current fixed decode lacks.

Parameters:
- XLEN, 32, datapath/register width (>=32; immediates sign-extended to XLEN).
- NREGS, 32, architectural registers; AW = $clog2(NREGS); register 0 hardwired to zero.
- STALLW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  decode accepts the instruction this cycle
- instr_i  in  32  instruction word
- pc_i  in  XLEN  PC of instr_i
- flush_i  in  1  branch/jump redirect; kill in-flight decode
- ex_ready_i  in  1  execute can accept
- ex_valid_o  out  1  ID/EX register holds a valid instruction
- ex_rs1_data_o  out  XLEN  rs1 operand
- ex_rs2_data_o  out  XLEN  rs2 operand
- ex_imm_o  out  XLEN  sign-extended immediate
- ex_pc_o  out  XLEN  PC
- ex_rd_o  out  AW  destination register
- ex_rd_we_o  out  1  instruction writes rd (rd!=0, format R/I/U/J)
- ex_is_load_o  out  1  opcode 0000011
- ex_fmt_o  out  3  R=0, I=1, S=2, B=3, U=4, J=5, illegal=7
- wb_we_i  in  1  write-back enable
- wb_rd_i  in  AW  write-back register
- wb_data_i  in  XLEN  write-back data
- stall_cnt_o  out  STALLW  saturating count of interlock bubbles

Behaviour:
- Reset (asynchronous): all ex_* outputs 0, ex_valid_o=0, stall_cnt_o=0, all registers 0.
- Register file:
  - write on posedge when wb_we_i && wb_rd_i!=0;
  - writes to register 0 are ignored; reads of register 0 return 0;
  - indices >= NREGS are treated as illegal (fmt=7).
- Format decode by opcode[6:0]:
  - 0110011 is R;
  - 0010011, 0000011, 1100111 are I;
  - 0100011 is S;
  - 1100011 is B;
  - 0110111, 0010111 are U;
  - 1101111 is J;
  - anything else is illegal (fmt=7, ex_rd_we_o=0).
- Immediates:
  - I = sext(instr[31:20]);
  - S = sext({instr[31:25], instr[11:7]});
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
  - U = {instr[31:12], 12'b0} sign-extended;
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
  - R/illegal = 0.
- Source use:
  - rs1 used for R/I/S/B;
  - rs2 used for R/S/B.
- advance = !ex_valid_o || ex_ready_i.
- Hazard: asserted when ex_valid_o && ex_is_load_o && ex_rd_o!=0 && (rs1 used and equal to ex_rd_o, or rs2 used and equal to ex_rd_o) && if_valid_i.
- if_ready_o = advance && !hazard, or flush_i.
- Each cycle, in priority order:
  1. flush_i=1: ex_valid_o <= 0; the incoming instruction is dropped; if_ready_o=1.
  2. advance && hazard: bubble, ex_valid_o <= 0; the ex_* payload is held; stall_cnt_o increments, saturating at all-ones.
  3. advance && if_valid_i: ex_* payload loaded; ex_valid_o <= 1. Latency is 1 cycle.
  4. advance && !if_valid_i: ex_valid_o <= 0.
  5. !advance: all ex_* held (back-pressure); no stall count.
- Operand read happens in the accepting cycle. Write-back in that same cycle to a used source is governed by the optional feature.
- Flush with simultaneous hazard: flush wins; no stall count.
- Reset mid-stall returns directly to the reset state.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a same-cycle write-back (wb_we_i, wb_rd_i!=0, wb_rd_i==rs) forwards wb_data_i into the operand captured into the ID/EX register.
- Undefined: no forwarding. A write-back whose wb_rd_i matches a used source of the incoming instruction raises hazard for that cycle. The result is one bubble counted in stall_cnt_o, and the instruction is accepted the next cycle with the updated value.

Test Plan:
- Reset, then feed addi x1,x0,5 (0x00500093) at pc=0x100, ex_ready=1 → next cycle ex_valid=1, fmt=1, imm=5, rd=1, rd_we=1, ex_pc=0x100.
- Write-back x2=0xDEADBEEF in the same cycle that add x3,x2,x2 (0x002101B3) is presented:
  - with the macro: accepted; rs1=rs2=0xDEADBEEF;
  - without it: one bubble, stall_cnt=1, then the same operands.
- Load-use: lw x5,0(x6) then add x7,x5,x0 → one bubble (ex_valid=0 for 1 cycle, if_ready=0), stall_cnt +1, then the add issues.
- Back-pressure: ex_ready=0 for 3 cycles with a valid instruction held → ex_* stable, if_ready=0, stall_cnt unchanged.
- flush_i during a load-use hazard → ex_valid=0 next cycle, if_ready=1, stall_cnt unchanged.
- Immediate decode:
  - beq with instr=0xFE000EE3 → fmt=3, imm=0xFFFFFFFC;
  - jal 0x7FFFF0EF → fmt=5, imm=0x000FFFFE;
  - write to x0 via write-back, then read x0 → 0.
